// File: rtl/ours_fifo_pkg.sv
// Shared helpers and types for the valid/ready FIFO and its wrap-around pointers.
package ours_fifo_pkg;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into a depth-entry array; at least one bit.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } fifo_op_t;

endpackage

// File: rtl/ours_fifo_wrap_ptr.sv
// Pointer counter that wraps from DEPTH-1 back to 0, for any DEPTH >= 1.
module ours_fifo_wrap_ptr
  import ours_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = fifo_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  // Wrap by compare so non-power-of-two depths never index past the array.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ours_fifo_flow.sv
// Valid/ready synchronous FIFO with occupancy count, registered threshold flags,
// synchronous flush and a sticky overflow diagnostic.
module ours_fifo_flow
  import ours_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_THR  = 3,
  parameter int unsigned AEMPTY_THR = 1,
  parameter int unsigned RSTN_EN    = 0,
  parameter int unsigned RSTN_WIDTH = 0,
  parameter int unsigned RSTN_LSB   = 0,
  localparam int unsigned CW = fifo_cnt_w(DEPTH),
  localparam int unsigned PW = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf_err
);

  // Bits of each entry cleared by reset; all-zero when the feature is off.
  function automatic logic [WIDTH-1:0] rst_mask_f();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (RSTN_EN != 0 && i >= RSTN_LSB && i < RSTN_LSB + RSTN_WIDTH) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] RST_MASK = rst_mask_f();

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count_q, count_d;
  logic             af_q, af_d, ae_q, ae_d, ovf_q, ovf_d;
  logic             full_c, empty_c;
  fifo_op_t         op;

  // Status is derived only from the registered count, so in_rdy never sees out_rdy.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign in_rdy  = ~full_c;
  assign out_vld = ~empty_c;

  assign op.flush = flush;
  assign op.push  = in_vld & in_rdy & ~flush;
  assign op.pop   = out_vld & out_rdy & ~flush;

  ours_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_head (
    .clk  (clk),
    .rstn (rstn),
    .clr  (op.flush),
    .inc  (op.pop),
    .ptr  (head)
  );

  ours_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk  (clk),
    .rstn (rstn),
    .clr  (op.flush),
    .inc  (op.push),
    .ptr  (tail)
  );

  // Next occupancy and the flags that track it in the same cycle.
  always_comb begin
    count_d = count_q;
    if (op.flush) begin
      count_d = '0;
    end else if (op.push && !op.pop) begin
      count_d = count_q + CW'(1);
    end else if (op.pop && !op.push) begin
      count_d = count_q - CW'(1);
    end
    af_d  = (count_d >= CW'(AFULL_THR));
    ae_d  = (count_d <= CW'(AEMPTY_THR));
    ovf_d = ovf_q | (in_vld & ~in_rdy);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
      af_q    <= (AFULL_THR == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage; reset only touches the configured field and leaves the rest intact.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i] & ~RST_MASK;
      end
    end else if (op.push) begin
      mem_q[tail] <= in_data;
    end
  end

  assign out_data     = mem_q[head];
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ovf_err      = ovf_q;

`ifndef SYNTHESIS
  logic             stall_q;
  logic [WIDTH-1:0] stall_data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      stall_q      <= in_vld & ~in_rdy;
      stall_data_q <= in_data;
      assert (AFULL_THR >= 1 && AFULL_THR <= DEPTH && AEMPTY_THR <= DEPTH - 1)
        else $error("threshold parameters out of range");
      assert (!(op.pop && count_q == '0))
        else $error("pop while empty");
      assert (count_q <= CW'(DEPTH))
        else $error("count above depth");
      assert (!(stall_q && in_vld && in_data != stall_data_q))
        else $warning("in_data changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_ours_fifo_flow.sv
// Directed bench for ours_fifo_flow: three configurations driven from one sequence,
// a queue scoreboard for data order and a count model for status outputs.
module tb_ours_fifo_flow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_ab, rstn_c;

  logic       a_flush, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_af, a_ae, a_ovf;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;
  logic       b_flush, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_af, b_ae, b_ovf;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_count;
  logic       c_flush, c_in_vld, c_in_rdy, c_out_vld, c_out_rdy, c_af, c_ae, c_ovf;
  logic [7:0] c_in_data, c_out_data;
  logic [0:0] c_count;

  ours_fifo_flow #(.WIDTH(8), .DEPTH(3), .AFULL_THR(2), .AEMPTY_THR(1)) u_a (
    .clk(clk), .rstn(rstn_ab), .flush(a_flush), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .in_data(a_in_data), .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_data(a_out_data),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae), .ovf_err(a_ovf));

  ours_fifo_flow #(.WIDTH(8), .DEPTH(4), .AFULL_THR(3), .AEMPTY_THR(1)) u_b (
    .clk(clk), .rstn(rstn_ab), .flush(b_flush), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .in_data(b_in_data), .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_data(b_out_data),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae), .ovf_err(b_ovf));

  ours_fifo_flow #(.WIDTH(8), .DEPTH(1), .AFULL_THR(1), .AEMPTY_THR(0),
                   .RSTN_EN(1), .RSTN_WIDTH(4), .RSTN_LSB(0)) u_c (
    .clk(clk), .rstn(rstn_c), .flush(c_flush), .in_vld(c_in_vld), .in_rdy(c_in_rdy),
    .in_data(c_in_data), .out_vld(c_out_vld), .out_rdy(c_out_rdy), .out_data(c_out_data),
    .count(c_count), .almost_full(c_af), .almost_empty(c_ae), .ovf_err(c_ovf));

  int         checks = 0;
  int         errors = 0;
  int         mcnt [3];
  bit         movf [3];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL u%0d %s observed=%0h expected=%0h", k, tag, obs, exp);
      end
  endtask

  function automatic logic [7:0] q_front(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void q_push(input int k, input logic [7:0] d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endfunction

  function automatic void model_reset(input int k);
    mcnt[k] = 0;
    movf[k] = 1'b0;
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Drive one instance; every other instance is held idle.
  task automatic drive(input int k, input logic vld, input logic rdy, input logic fl, input logic [7:0] d);
    {a_in_vld, a_out_rdy, a_flush} = 3'b000;
    {b_in_vld, b_out_rdy, b_flush} = 3'b000;
    {c_in_vld, c_out_rdy, c_flush} = 3'b000;
    case (k)
      0:       begin a_in_vld = vld; a_out_rdy = rdy; a_flush = fl; a_in_data = d; end
      1:       begin b_in_vld = vld; b_out_rdy = rdy; b_flush = fl; b_in_data = d; end
      default: begin c_in_vld = vld; c_out_rdy = rdy; c_flush = fl; c_in_data = d; end
    endcase
  endtask

  // Check settled outputs against the model, then drive this cycle's request.
  task automatic step(input int k, input logic vld, input logic rdy, input logic fl, input logic [7:0] d);
    logic        ov, ir, af, ae, ovf;
    logic [7:0]  od;
    logic [31:0] cnt;
    int          dep, aft, aet;
    bit          pu, po;
    @(negedge clk);
    case (k)
      0: begin ov = a_out_vld; ir = a_in_rdy; af = a_af; ae = a_ae; ovf = a_ovf;
               od = a_out_data; cnt = 32'(a_count); dep = 3; aft = 2; aet = 1; end
      1: begin ov = b_out_vld; ir = b_in_rdy; af = b_af; ae = b_ae; ovf = b_ovf;
               od = b_out_data; cnt = 32'(b_count); dep = 4; aft = 3; aet = 1; end
      default: begin ov = c_out_vld; ir = c_in_rdy; af = c_af; ae = c_ae; ovf = c_ovf;
               od = c_out_data; cnt = 32'(c_count); dep = 1; aft = 1; aet = 0; end
    endcase
    chk(k, "count", cnt, 32'(mcnt[k]));
    chk(k, "out_vld", 32'(ov), 32'(mcnt[k] > 0));
    chk(k, "in_rdy", 32'(ir), 32'(mcnt[k] < dep));
    chk(k, "almost_full", 32'(af), 32'(mcnt[k] >= aft));
    chk(k, "almost_empty", 32'(ae), 32'(mcnt[k] <= aet));
    chk(k, "ovf_err", 32'(ovf), 32'(movf[k]));
    if (vld && mcnt[k] == dep) movf[k] = 1'b1;
    if (rdy && mcnt[k] > 0) chk(k, "out_data", 32'(od), 32'(q_front(k)));
    if (fl) begin
      mcnt[k] = 0;
      case (k)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end else begin
      pu = vld && (mcnt[k] < dep);
      po = rdy && (mcnt[k] > 0);
      if (po) q_pop(k);
      if (pu) q_push(k, d);
      mcnt[k] = mcnt[k] + int'(pu) - int'(po);
    end
    drive(k, vld, rdy, fl, d);
  endtask

  initial begin
    rstn_ab   = 1'b0;
    rstn_c    = 1'b0;
    a_in_data = '0;
    b_in_data = '0;
    c_in_data = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rstn_ab = 1'b1;
    rstn_c  = 1'b1;
    for (int k = 0; k < 3; k++) model_reset(k);

    // Non-power-of-two fill and drain.
    step(0, 1, 0, 0, 8'h0A);
    step(0, 1, 0, 0, 8'h0B);
    step(0, 1, 0, 0, 8'h0C);
    repeat (3) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Steady push+pop at count 2 so both pointers wrap repeatedly.
    step(0, 1, 0, 0, 8'h40);
    step(0, 1, 0, 0, 8'h41);
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 8'(32'h42 + i));
    repeat (2) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Full with push and pop requested: only the pop goes, overflow is flagged.
    step(0, 1, 0, 0, 8'h31);
    step(0, 1, 0, 0, 8'h32);
    step(0, 1, 0, 0, 8'h33);
    step(0, 1, 1, 0, 8'h34);
    step(0, 1, 0, 0, 8'h34);
    repeat (3) step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Threshold flags across counts 0..4.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 8'(32'h10 + i));
    step(1, 0, 0, 0, 8'h00);

    // Flush at count 2 with push and pop in the same cycle.
    repeat (2) step(1, 0, 1, 0, 8'h00);
    step(1, 1, 1, 1, 8'hEE);
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h21);
    step(1, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);

    // Single-entry FIFO, then reset mid-traffic with flush also asserted.
    step(2, 1, 0, 0, 8'h5A);
    step(2, 1, 0, 0, 8'h77);
    @(negedge clk);
    rstn_c = 1'b0;
    drive(2, 1'b1, 1'b1, 1'b1, 8'h77);
    @(negedge clk);
    rstn_c = 1'b1;
    drive(2, 1'b0, 1'b0, 1'b0, 8'h77);
    model_reset(2);
    step(2, 0, 0, 0, 8'h00);
    @(negedge clk);
    chk(2, "rst_field", 32'(c_out_data[3:0]), 32'h0);
    chk(2, "kept_field", 32'(c_out_data[7:4]), 32'h5);
    step(2, 1, 0, 0, 8'h3C);
    step(2, 1, 1, 0, 8'h44);
    step(2, 1, 0, 0, 8'h44);
    step(2, 0, 1, 0, 8'h00);
    step(2, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
